ram_req_scheduler: RTL and testbench
====================================

// Module: ram_req_scheduler
// PURPOSE
//  Memory-side controller for the on-chip RAM node. Accepts read/write request packets
//  from the NoC router port and queues them in a request FIFO. Executes them one at a
//  time on a single-port synchronous RAM and returns one response packet per valid request,
//  routed back to the source node. Each response is the credit return to that traffic generator.
// PARAMETERS
//  WIDTH        8                      data word width
//  ADDR_WIDTH   7                      RAM address width
//  N            16                     NoC node count
//  N_ADDR_WIDTH $clog2(N)              node id width
//  NODE         0                      this (memory) node id, placed in every response
//  FIFO_DEPTH   4                      request FIFO entries, power of 2, >=2
//  ACK_WORD     1<<(WIDTH-1)           data returned for a write ack (8'h80 at WIDTH=8)
//  PACKED_IN    WIDTH+ADDR_WIDTH+N_ADDR_WIDTH+2    request packet width
//  PACKED_OUT   WIDTH+N_ADDR_WIDTH                 response packet width
// PORTS
//  clk           in   1             clock
//  rst           in   1             async reset, active-low (rst==0 resets)
//  i_packed_in   in   PACKED_IN     {data,addr,write_en,read_en,src}, MSB first
//  i_valid_in    in   1             request valid
//  i_ready_out   out  1             request FIFO can accept
//  o_packed_out  out  PACKED_OUT    {data,NODE}
//  o_dest_out    out  N_ADDR_WIDTH  destination = request src
//  o_valid_out   out  1             response valid
//  o_ready_in    in   1             NoC accepts response
//  mem_en        out  1             RAM access strobe
//  mem_we        out  1             RAM write enable
//  mem_addr      out  ADDR_WIDTH    RAM address
//  mem_wdata     out  WIDTH         RAM write data
//  mem_rdata     in   WIDTH         RAM read data, valid 1 cycle after mem_en&&!mem_we
//  err_count     out  8             malformed-request counter, saturates at 255
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, i_ready_out=0, o_valid_out=0, o_packed_out=0, o_dest_out=0.
//   Also mem_en=0, mem_we=0, err_count=0.
//  Reset mid-operation: queued and in-flight requests are discarded; no response is emitted.
//  Input: a request is accepted on an edge where i_valid_in && i_ready_out.
//   i_ready_out = !fifo_full, registered: it may be 0 for one cycle after the FIFO drains.
//   It is never 1 while the FIFO is full.
//  FIFO full + accept attempt: ignored (ready is 0). A pop and a push on the same edge are both honoured.
//  FSM (one request in service):
//   IDLE:  if FIFO not empty, pop the head into the req registers.
//          If write_en^read_en, go to ISSUE. Otherwise (both or neither set) drop it,
//          err_count++ (saturating), and stay in IDLE.
//   ISSUE: mem_en=1, mem_we=req.write_en, mem_addr=req.addr, mem_wdata=req.data
//          (combinational from state and req); go to WAIT.
//   WAIT:  o_data <= write ? ACK_WORD : mem_rdata; o_dest_out <= req.src; o_valid_out <= 1; go to RESP.
//   RESP:  hold all outputs stable. When o_ready_in is 1: o_valid_out <= 0, go to IDLE.
//  mem_en/mem_we are 0 outside ISSUE.
//  Latency: accept at edge E0, pop at E1, RAM samples at E2, o_valid_out=1 after E3.
//   Minimum service interval is 4 cycles per request.
//  Responses are returned in request-acceptance order, exactly one per well-formed request.
//  Back-to-back writes then a read to the same addr: the read returns the last written data.
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//   full: MSBs differ and the rest are equal. empty: pointers equal.
// TESTING
//  1 Write addr=5 data=3 src=2, o_ready_in=1 -> mem_we=1 @addr5; response {8'h80,NODE},
//    dest=2, o_valid_out exactly 3 edges after accept.
//  2 Write addr=9 data=0x5A, then read addr=9 src=7 -> second response data=0x5A, dest=7, in order.
//  3 Push 5 requests back-to-back with o_ready_in=0, FIFO_DEPTH=4 ->
//    i_ready_out drops once 4 are queued; all 5 responses arrive in order after ready rises.
//  4 Hold o_ready_in=0 for 10 cycles during RESP -> o_valid_out, o_packed_out and
//    o_dest_out stay stable; no new mem_en is issued.
//  5 Request with write_en=read_en=1, then a valid read -> no response for the first,
//    err_count=1, read served normally. Saturation check: 300 bad requests -> err_count=255.
//  6 Assert rst low in WAIT with 2 requests queued -> all outputs at reset values
//    within the same cycle, no responses afterwards, and the next request is served normally.

Source files
------------

// File: rtl/ram_req_scheduler.sv
// Memory-side request scheduler: queues NoC read/write requests in a small FIFO, runs them
// one at a time on a single-port synchronous RAM and returns one response per valid request.
module ram_req_scheduler #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      ADDR_WIDTH   = 7,
  parameter int unsigned      N            = 16,
  parameter int unsigned      N_ADDR_WIDTH = $clog2(N),
  parameter int unsigned      NODE         = 0,
  parameter int unsigned      FIFO_DEPTH   = 4,
  parameter logic [WIDTH-1:0] ACK_WORD     = {1'b1, {(WIDTH-1){1'b0}}},
  parameter int unsigned      PACKED_IN    = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
  parameter int unsigned      PACKED_OUT   = WIDTH + N_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKED_IN-1:0]    i_packed_in,
  input  logic                    i_valid_in,
  output logic                    i_ready_out,
  output logic [PACKED_OUT-1:0]   o_packed_out,
  output logic [N_ADDR_WIDTH-1:0] o_dest_out,
  output logic                    o_valid_out,
  input  logic                    o_ready_in,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  output logic [7:0]              err_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W    = PTR_W - 1;
  localparam int unsigned RE_BIT   = N_ADDR_WIDTH;
  localparam int unsigned WE_BIT   = N_ADDR_WIDTH + 1;
  localparam int unsigned ADDR_LSB = N_ADDR_WIDTH + 2;
  localparam int unsigned DATA_LSB = ADDR_LSB + ADDR_WIDTH;

  localparam logic [N_ADDR_WIDTH-1:0] NODE_ID = N_ADDR_WIDTH'(NODE);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Request FIFO
  logic [PACKED_IN-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 ready_q, ready_d;
  logic                 fifo_empty, full_d;
  logic                 push, pop;
  logic [PACKED_IN-1:0] head;

  // Service state
  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        req_data_q, req_data_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic                    req_we_q, req_we_d;
  logic [N_ADDR_WIDTH-1:0] req_src_q, req_src_d;
  logic [PACKED_OUT-1:0]   out_pk_q, out_pk_d;
  logic [N_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                    valid_q, valid_d;
  logic [7:0]              err_q, err_d;
  logic                    head_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = fifo_mem[rd_ptr_q[IDX_W-1:0]];
  assign head_ok    = head[WE_BIT] ^ head[RE_BIT];

  // ready_q is only ever 1 when the FIFO has room, so push needs no separate full check
  assign push = i_valid_in && ready_q;
  assign pop  = (state_q == StIdle) && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    full_d   = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
               (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
    ready_d  = !full_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[IDX_W-1:0]] <= i_packed_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_data_d = req_data_q;
    req_addr_d = req_addr_q;
    req_we_d   = req_we_q;
    req_src_d  = req_src_q;
    out_pk_d   = out_pk_q;
    dest_d     = dest_q;
    valid_d    = valid_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          req_data_d = head[DATA_LSB +: WIDTH];
          req_addr_d = head[ADDR_LSB +: ADDR_WIDTH];
          req_we_d   = head[WE_BIT];
          req_src_d  = head[N_ADDR_WIDTH-1:0];
          if (head_ok) begin
            state_d = StIssue;
          end else if (err_q != 8'hff) begin
            // Malformed request (both or neither enable set): dropped without a response
            err_d = err_q + 8'd1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        out_pk_d = {(req_we_q ? ACK_WORD : mem_rdata), NODE_ID};
        dest_d   = req_src_q;
        valid_d  = 1'b1;
        state_d  = StResp;
      end
      StResp: begin
        if (o_ready_in) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      req_data_q <= '0;
      req_addr_q <= '0;
      req_we_q   <= 1'b0;
      req_src_q  <= '0;
      out_pk_q   <= '0;
      dest_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_data_q <= req_data_d;
      req_addr_q <= req_addr_d;
      req_we_q   <= req_we_d;
      req_src_q  <= req_src_d;
      out_pk_q   <= out_pk_d;
      dest_q     <= dest_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_en && req_we_q;
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_data_q;

  assign i_ready_out  = ready_q;
  assign o_packed_out = out_pk_q;
  assign o_dest_out   = dest_q;
  assign o_valid_out  = valid_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_ram_req_scheduler.sv
// Randomized bench for ram_req_scheduler: a RAM model, a shadow-memory response predictor
// and one task per scenario comparing observed responses against predicted ones.
module tb_ram_req_scheduler;

  localparam int PI = 21;
  localparam int PO = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PI-1:0] i_packed_in = '0;
  logic          i_valid_in = 1'b0;
  logic          i_ready_out;
  logic [PO-1:0] o_packed_out;
  logic [3:0]    o_dest_out;
  logic          o_valid_out;
  logic          o_ready_in = 1'b1;
  logic          mem_en, mem_we;
  logic [6:0]    mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [7:0]    err_count;

  int checks = 0;
  int failures = 0;

  ram_req_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_packed_in  (i_packed_in),
    .i_valid_in   (i_valid_in),
    .i_ready_out  (i_ready_out),
    .o_packed_out (o_packed_out),
    .o_dest_out   (o_dest_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, contents survive reset
  logic [7:0] ram [128];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'(i * 29 + 11);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: requests are served in acceptance order, so the predicted response can
  // be computed from a shadow memory at the moment a request is accepted.
  logic [7:0]  shadow [128];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          err_exp = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      err_exp = 0;
      for (int i = 0; i < 128; i++) shadow[i] = ram[i];
    end else begin
      if (i_valid_in && i_ready_out) begin
        logic [7:0] d;
        logic [6:0] a;
        logic       we, re;
        logic [3:0] s;
        {d, a, we, re, s} = i_packed_in;
        if (we ^ re) begin
          if (we) begin
            shadow[a] = d;
            exp_q.push_back({s, 8'h80, 4'd0});
          end else begin
            exp_q.push_back({s, shadow[a], 4'd0});
          end
        end else if (err_exp < 255) begin
          err_exp = err_exp + 1;
        end
      end
      if (o_valid_out && o_ready_in) obs_q.push_back({o_dest_out, o_packed_out});
    end
  end

  function automatic logic [PI-1:0] mk(input logic [7:0] d, input logic [6:0] a,
                                       input logic we, input logic re, input logic [3:0] s);
    return {d, a, we, re, s};
  endfunction

  function automatic logic [PI-1:0] rand_good(input int amax);
    logic we;
    we = 1'($urandom_range(0, 1));
    return mk(8'($urandom), 7'($urandom_range(0, amax)), we, !we, 4'($urandom));
  endfunction

  // Drives one request starting at posedge+1 and returns at posedge+1 after it is accepted
  task automatic send_req(input logic [PI-1:0] p);
    int t = 0;
    i_packed_in = p;
    i_valid_in  = 1'b1;
    while (!i_ready_out && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (!i_ready_out) begin
      failures++;
      $display("FAIL send_timeout: i_ready_out=%0b required 1", i_ready_out);
    end else begin
      @(posedge clk); #1;
    end
    i_valid_in = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 600 && obs_q.size() < exp_q.size(); i++) begin
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i_ready_out, o_valid_out, mem_en, mem_we} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy/vld/en/we=%b required 0000",
               {i_ready_out, o_valid_out, mem_en, mem_we});
    end
    checks++;
    if ({o_packed_out, o_dest_out, err_count} !== 24'h0) begin
      failures++;
      $display("FAIL reset_data: got pk=%h dest=%h err=%h required 0", o_packed_out,
               o_dest_out, err_count);
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (i_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: got %b required 1", i_ready_out);
    end
  endtask

  task automatic test_single_write();
    int n = 0;
    logic [15:0] e, o;
    o_ready_in  = 1'b1;
    i_packed_in = mk(8'd3, 7'd5, 1'b1, 1'b0, 4'd2);
    i_valid_in  = 1'b1;
    @(posedge clk); #1;
    i_valid_in = 1'b0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 7'd5, 8'd3}) begin
          failures++;
          $display("FAIL write_mem_issue: got en=%b we=%b addr=%0d wd=%h required 1 1 5 03",
                   mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (o_valid_out) break;
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL write_latency: got %0d edges required 3", n);
    end
    checks++;
    if ({o_dest_out, o_packed_out} !== 16'h2800) begin
      failures++;
      $display("FAIL write_ack: got dest=%h pk=%h required dest=2 pk=800", o_dest_out,
               o_packed_out);
    end
    wait_resp();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL write_count: got %0d responses required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL write_resp: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_write_read();
    logic [15:0] e, o;
    o_ready_in = 1'b1;
    send_req(mk(8'h5a, 7'd9, 1'b1, 1'b0, 4'd3));
    send_req(mk(8'h00, 7'd9, 1'b0, 1'b1, 4'd7));
    wait_resp();
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL wr_rd_count: got %0d responses required 2", obs_q.size());
    end
    for (int i = 0; i < 2 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wr_rd_resp%0d: got %h required %h", i, o, e);
      end
      if (i == 1) begin
        checks++;
        if (o !== 16'h75a0) begin
          failures++;
          $display("FAIL wr_rd_readback: got %h required 75a0", o);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e, o;
    o_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) send_req(rand_good(15));
    checks++;
    if (i_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_ready: got %b required 0", i_ready_out);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (i_ready_out !== 1'b0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL bp_stall: got ready=%b resp=%0d required ready=0 resp=0", i_ready_out,
               obs_q.size());
    end
    o_ready_in = 1'b1;
    wait_resp();
    checks++;
    if (obs_q.size() != 5 || exp_q.size() != 5) begin
      failures++;
      $display("FAIL bp_count: got %0d responses required 5", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bp_order: got %h required %h", o, e);
      end
    end
    checks++;
    if (i_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_rise: got %b required 1", i_ready_out);
    end
  endtask

  task automatic test_resp_hold();
    logic [15:0] e, o, held;
    int t = 0;
    o_ready_in = 1'b0;
    send_req(mk(8'h00, 7'($urandom_range(0, 127)), 1'b0, 1'b1, 4'd11));
    send_req(rand_good(127));
    while (!o_valid_out && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    held = {o_dest_out, o_packed_out};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_valid_out, mem_en, o_dest_out, o_packed_out} !== {1'b1, 1'b0, held}) begin
        failures++;
        $display("FAIL hold_c%0d: got vld=%b en=%b out=%h required vld=1 en=0 out=%h", i,
                 o_valid_out, mem_en, {o_dest_out, o_packed_out}, held);
      end
    end
    o_ready_in = 1'b1;
    wait_resp();
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL hold_count: got %0d responses required 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL hold_resp: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_malformed();
    logic [15:0] e, o;
    logic        both;
    o_ready_in = 1'b1;
    send_req(mk(8'h11, 7'd20, 1'b1, 1'b1, 4'd4));
    send_req(mk(8'h00, 7'd9, 1'b0, 1'b1, 4'd6));
    wait_resp();
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("FAIL bad_err1: got %0d required 1", err_count);
    end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL bad_count: got %0d responses required 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bad_read: got %h required %h", o, e);
      end
    end
    for (int i = 0; i < 300; i++) begin
      both = 1'($urandom_range(0, 1));
      send_req(mk(8'($urandom), 7'($urandom), both, both, 4'($urandom)));
    end
    wait_resp();
    checks++;
    if (err_count !== 8'(err_exp) || err_exp != 255) begin
      failures++;
      $display("FAIL bad_saturate: got %0d required %0d", err_count, err_exp);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL bad_no_resp: got %0d responses required 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e, o;
    o_ready_in = 1'b1;
    send_req(mk(8'h00, 7'd9, 1'b0, 1'b1, 4'd1));
    send_req(mk(8'hc3, 7'd9, 1'b1, 1'b0, 4'd2));
    send_req(mk(8'h3c, 7'd10, 1'b1, 1'b0, 4'd3));
    rst = 1'b0;
    #1;
    checks++;
    if ({i_ready_out, o_valid_out, mem_en, mem_we, o_packed_out, o_dest_out, err_count}
        !== 28'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: got rdy=%b vld=%b en=%b we=%b pk=%h dest=%h err=%h req 0",
               i_ready_out, o_valid_out, mem_en, mem_we, o_packed_out, o_dest_out, err_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_no_resp: got %0d responses required 0", obs_q.size());
    end
    obs_q.delete();
    send_req(mk(8'h00, 7'd9, 1'b0, 1'b1, 4'd5));
    wait_resp();
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL rstmid_count: got %0d responses required 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstmid_resp: got %h required %h", o, e);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e, o;
    logic        both;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      o_ready_in = ($urandom_range(0, 3) != 0);
      if (!i_ready_out) o_ready_in = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        both = 1'($urandom_range(0, 1));
        send_req(mk(8'($urandom), 7'($urandom_range(0, 7)), both, both, 4'($urandom)));
      end else begin
        send_req(rand_good(7));
      end
    end
    o_ready_in = 1'b1;
    wait_resp();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d responses required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rand_resp: got %h required %h", o, e);
      end
    end
    checks++;
    if (err_count !== 8'(err_exp)) begin
      failures++;
      $display("FAIL rand_err: got %0d required %0d", err_count, err_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_backpressure();
    test_resp_hold();
    test_malformed();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
